mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles waited for dmem_ack before the access is aborted.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ctrl_wb_in  input  2  writeback controls from EX/MEM.
REQ-005 SHALL have port mem_read_in  input  1  load request from EX/MEM.
REQ-006 SHALL have port mem_write_in  input  1  store request from EX/MEM.
REQ-007 SHALL have port alu_result_in  input  32  address or ALU result.
REQ-008 SHALL have port wdata_in  input  32  store data.
REQ-009 SHALL have port rd_in  input  5  destination register.
REQ-010 SHALL have port dmem_req  output  1  memory request, held high until acknowledged.
REQ-011 SHALL have port dmem_we  output  1  1 = write, 0 = read.
REQ-012 SHALL have ports dmem_addr and dmem_wdata  output  32 each  address and write data for the request.
REQ-013 SHALL have port dmem_ack  input  1  one-cycle completion from memory.
REQ-014 SHALL have port dmem_rdata  input  32  read data, valid when dmem_ack = 1.
REQ-015 SHALL have port stall  output  1  hold request to upstream stages.
REQ-016 SHALL have ports ctrl_wb_out (2), mem_data_out (32), alu_result_out (32), rd_out (5)  outputs  MEM/WB register contents.
REQ-017 SHALL have ports misalign_err and timeout_err  output  1 each  one-cycle error pulses.

Function
REQ-018 The FSM SHALL have two states, IDLE and BUSY.
REQ-019 Op classification: op = mem_read_in | mem_write_in; aligned = (alu_result_in[1:0] == 0); if both read and write are set, the access SHALL be treated as a write.
REQ-020 In IDLE with op = 0, the MEM/WB outputs SHALL load ctrl_wb_in, alu_result_in, rd_in with 1-cycle latency; mem_data_out SHALL keep its value; stall SHALL be 0.
REQ-021 In IDLE with op & aligned, the block SHALL latch address, data and we; enter BUSY on the next edge; drive stall = 1 combinationally in that cycle; load a bubble (ctrl_wb_out = 0) into MEM/WB.
REQ-022 In BUSY, dmem_req SHALL be 1, with dmem_we/addr/wdata taken from the latched values and held stable.
REQ-023 In BUSY, stall SHALL be 1 except in the cycle where dmem_ack = 1 or the timeout expires.
REQ-024 In BUSY with dmem_ack = 1:
- at the next edge, mem_data_out <= dmem_rdata (reads only; writes leave it unchanged), ctrl_wb_out <= latched ctrl_wb, alu_result_out and rd_out <= latched values;
- the FSM SHALL return to IDLE.
REQ-025 While stalled, MEM/WB SHALL load a bubble each cycle, so no writeback is duplicated.
REQ-026 The wait counter SHALL:
- clear on entering BUSY and increment each BUSY cycle without ack;
- when it reaches TIMEOUT-1 without ack, drop dmem_req at the next edge, return to IDLE, load a bubble, pulse timeout_err, and release stall in that cycle.
REQ-027 A dmem_ack arriving in IDLE SHALL be ignored.
REQ-028 In IDLE with op & !aligned, the block SHALL issue no request, load a bubble, pulse misalign_err at the next edge, and hold stall = 0.
REQ-029 Ack and timeout in the same cycle: ack SHALL take priority, and no error SHALL be raised.

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously set state = IDLE and clear the counter, dmem_req, dmem_we, dmem_addr, dmem_wdata, all MEM/WB outputs and both error flags to 0; stall SHALL be 0.
REQ-031 Reset asserted during BUSY SHALL abandon the access immediately, with no pulse on any output after reset release.

Structure
REQ-032 The state encoding (IDLE/BUSY) and the ctrl_wb bit positions SHALL live in a shared pipeline package.
REQ-033 The block SHALL be a single module containing the FSM, the request latch and the MEM/WB register; no sub-module SHALL be used.

Verification
REQ-034 Pass-through test: op = 0, alu_result_in = 0x1234, rd_in = 7, ctrl_wb_in = 2'b10 -> the next cycle shows alu_result_out = 0x1234, rd_out = 7, ctrl_wb_out = 2'b10, stall never asserted.
REQ-035 Load test: read of 0x100 with ack on the 3rd BUSY cycle and rdata = 0xDEADBEEF -> stall high for 3 cycles, dmem_req high for 3 cycles, then mem_data_out = 0xDEADBEEF and rd_out = rd_in.
REQ-036 Store test: read = write = 1 at address 0x200 with wdata = 0x55 -> dmem_we = 1, dmem_wdata = 0x55 while requesting; mem_data_out unchanged after ack.
REQ-037 Misaligned test: read at 0x102 -> dmem_req stays 0, misalign_err pulses 1 cycle, ctrl_wb_out = 0.
REQ-038 Timeout test: TIMEOUT = 4, no ack -> req high for 4 cycles, timeout_err pulses, stall falls, state = IDLE.
REQ-039 Mid-access reset test: rst_n low in the 2nd BUSY cycle -> dmem_req and stall drop asynchronously, all outputs 0, and a late ack after release is ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding and writeback-control bit layout.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ctrl_wb layout carried from EX/MEM into MEM/WB
    localparam int CTRL_WB_W          = 2;
    localparam int CTRL_WB_REG_WRITE  = 0;
    localparam int CTRL_WB_MEM_TO_REG = 1;

    // A bubble must never write the register file nor select memory data.
    localparam logic [CTRL_WB_W-1:0] CTRL_WB_BUBBLE =
        ~((CTRL_WB_W'(1) << CTRL_WB_REG_WRITE) | (CTRL_WB_W'(1) << CTRL_WB_MEM_TO_REG));

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues load/store to data memory, holds MEM/WB register, flags misalign/timeout.
// Latency: pass-through 1 cycle; memory op 1 issue cycle + BUSY cycles until ack (max TIMEOUT).
// Backpressure: stall held high from issue until the cycle dmem_ack arrives or the wait expires.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ctrl_wb_in, mem_read_in, mem_write_in, alu_result_in, wdata_in, rd_in   EX/MEM inputs
//   dmem_req/we/addr/wdata (out), dmem_ack/rdata (in)                      data-memory handshake
//   stall                           hold request to upstream stages
//   ctrl_wb_out, mem_data_out, alu_result_out, rd_out                      MEM/WB register
//   misalign_err, timeout_err       one-cycle error pulses
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CTRL_WB_W-1:0] ctrl_wb_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [31:0]          alu_result_in,
    input  logic [31:0]          wdata_in,
    input  logic [4:0]           rd_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata,
    output logic                 stall,
    output logic [CTRL_WB_W-1:0] ctrl_wb_out,
    output logic [31:0]          mem_data_out,
    output logic [31:0]          alu_result_out,
    output logic [4:0]           rd_out,
    output logic                 misalign_err,
    output logic                 timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CTRL_WB_W-1:0] lat_ctrl_wb;
    logic [4:0]           lat_rd;

    logic op, aligned;
    logic start, misalign, done, expire, stall_c;

    assign op      = mem_read_in | mem_write_in;
    assign aligned = is_word_aligned(alu_result_in[1:0]);

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        start     = 1'b0;
        misalign  = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op && aligned) begin
                    start     = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = ST_BUSY;
                end else if (op) begin
                    misalign  = 1'b1;
                end
            end
            ST_BUSY: begin
                // ack is checked first so an ack on the last wait cycle wins over the timeout
                if (dmem_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // stall must read 0 throughout reset even if upstream presents a memory op
    assign stall = stall_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            lat_ctrl_wb    <= '0;
            lat_rd         <= '0;
            ctrl_wb_out    <= '0;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            misalign_err   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            misalign_err <= misalign;
            timeout_err  <= expire;

            if (state == ST_IDLE) begin
                if (!op) begin
                    ctrl_wb_out    <= ctrl_wb_in;
                    alu_result_out <= alu_result_in;
                    rd_out         <= rd_in;
                end else begin
                    ctrl_wb_out    <= CTRL_WB_BUBBLE;
                end
                if (start) begin
                    // read+write together is treated as a write
                    dmem_req    <= 1'b1;
                    dmem_we     <= mem_write_in;
                    dmem_addr   <= alu_result_in;
                    dmem_wdata  <= wdata_in;
                    lat_ctrl_wb <= ctrl_wb_in;
                    lat_rd      <= rd_in;
                    wait_cnt    <= '0;
                end
            end else begin
                if (done) begin
                    dmem_req       <= 1'b0;
                    ctrl_wb_out    <= lat_ctrl_wb;
                    alu_result_out <= dmem_addr;
                    rd_out         <= lat_rd;
                    if (!dmem_we) begin
                        mem_data_out <= dmem_rdata;
                    end
                end else if (expire) begin
                    dmem_req    <= 1'b0;
                    ctrl_wb_out <= CTRL_WB_BUBBLE;
                end else begin
                    wait_cnt    <= wait_cnt + CNT_W'(1);
                    ctrl_wb_out <= CTRL_WB_BUBBLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl_wb_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] alu_result_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [1:0]  ctrl_wb_out;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        misalign_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_mem;   // reference copy of mem_data_out

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_wb_in(ctrl_wb_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .alu_result_in(alu_result_in), .wdata_in(wdata_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .ctrl_wb_out(ctrl_wb_out), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction from EX/MEM, held upstream while stall is high.
    // ack_at = BUSY cycle (1..TO) in which memory acks; > TO means never.
    task automatic run_instr(input logic [1:0] cw, input logic [4:0] rd, input logic [31:0] addr,
                             input logic [31:0] wd, input logic rdv, input logic wrv,
                             input int ack_at, input logic [31:0] rdata);
        logic op, al, done;
        int   nstall, nreq, exp_k;
        op = rdv | wrv;
        al = (addr[1:0] == 2'b00);
        ctrl_wb_in = cw; rd_in = rd; alu_result_in = addr; wdata_in = wd;
        mem_read_in = rdv; mem_write_in = wrv;
        // stray ack while idle must be ignored
        dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
        #1;
        chk("issue_stall", 32'(stall), 32'(op && al));
        nstall = stall ? 1 : 0;
        step();
        dmem_ack = 1'b0;
        if (!op) begin
            chk("pt_ctrl", 32'(ctrl_wb_out), 32'(cw));
            chk("pt_alu", alu_result_out, addr);
            chk("pt_rd", 32'(rd_out), 32'(rd));
            chk("pt_mdata", mem_data_out, m_mem);
            chk("pt_req", 32'(dmem_req), 32'd0);
            chk("pt_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
        end else if (!al) begin
            chk("mis_ctrl", 32'(ctrl_wb_out), 32'd0);
            chk("mis_err", 32'(misalign_err), 32'd1);
            chk("mis_req", 32'(dmem_req), 32'd0);
            chk("mis_mdata", mem_data_out, m_mem);
            chk("mis_tmo", 32'(timeout_err), 32'd0);
        end else begin
            nreq = 0;
            done = 1'b0;
            for (int b = 1; b <= TO && !done; b++) begin
                // upstream contents are irrelevant while busy; latched values must be used
                alu_result_in = $urandom; wdata_in = $urandom; rd_in = 5'($urandom);
                ctrl_wb_in = 2'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
                chk("busy_req", 32'(dmem_req), 32'd1);
                chk("busy_we", 32'(dmem_we), 32'(wrv));
                chk("busy_addr", dmem_addr, addr);
                chk("busy_wdata", dmem_wdata, wd);
                chk("busy_bubble", 32'(ctrl_wb_out), 32'd0);
                chk("busy_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
                nreq++;
                if (b == ack_at) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                    #1;
                    chk("ack_stall", 32'(stall), 32'd0);
                    step();
                    dmem_ack = 1'b0;
                    chk("ack_req", 32'(dmem_req), 32'd0);
                    chk("ack_ctrl", 32'(ctrl_wb_out), 32'(cw));
                    chk("ack_alu", alu_result_out, addr);
                    chk("ack_rd", 32'(rd_out), 32'(rd));
                    if (!wrv) m_mem = rdata;
                    chk("ack_mdata", mem_data_out, m_mem);
                    chk("ack_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
                    done = 1'b1;
                end else if (b == TO) begin
                    #1;
                    chk("tmo_stall", 32'(stall), 32'd0);
                    step();
                    chk("tmo_req", 32'(dmem_req), 32'd0);
                    chk("tmo_ctrl", 32'(ctrl_wb_out), 32'd0);
                    chk("tmo_err", 32'(timeout_err), 32'd1);
                    chk("tmo_mis", 32'(misalign_err), 32'd0);
                    chk("tmo_mdata", mem_data_out, m_mem);
                    done = 1'b1;
                end else begin
                    #1;
                    chk("wait_stall", 32'(stall), 32'd1);
                    if (stall) nstall++;
                    step();
                end
            end
            exp_k = (ack_at <= TO) ? ack_at : TO;
            chk("stall_cycles", 32'(nstall), 32'(exp_k));
            chk("req_cycles", 32'(nreq), 32'(exp_k));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        r, w;
        int          kind;

        // reset with a memory op presented upstream: stall must stay low
        rst_n = 1'b0;
        ctrl_wb_in = 2'b11; mem_read_in = 1'b1; mem_write_in = 1'b0;
        alu_result_in = 32'h40; wdata_in = 32'h0; rd_in = 5'd1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        m_mem = 32'h0;
        #7;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ctrl", 32'(ctrl_wb_out), 32'd0);
        chk("rst_mdata", mem_data_out, 32'd0);
        chk("rst_alu", alu_result_out, 32'd0);
        chk("rst_misc", {25'd0, dmem_we, rd_out, misalign_err}, 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        mem_read_in = 1'b0;
        #5 rst_n = 1'b1;
        step();

        // directed scenarios
        run_instr(2'b10, 5'd7, 32'h1234, 32'h0, 1'b0, 1'b0, 1, 32'h0);           // pass-through
        run_instr(2'b11, 5'd9, 32'h100, 32'h0, 1'b1, 1'b0, 3, 32'hDEADBEEF);     // load, ack on 3rd
        run_instr(2'b01, 5'd4, 32'h200, 32'h55, 1'b1, 1'b1, 2, 32'hCAFEF00D);    // read+write = store
        run_instr(2'b11, 5'd3, 32'h102, 32'h0, 1'b1, 1'b0, 1, 32'h0);            // misaligned
        run_instr(2'b11, 5'd6, 32'h300, 32'h0, 1'b1, 1'b0, TO + 1, 32'h0);       // timeout
        run_instr(2'b11, 5'd8, 32'h304, 32'h0, 1'b1, 1'b0, TO, 32'h13572468);    // ack on last cycle
        run_instr(2'b10, 5'd2, 32'h7777, 32'h0, 1'b0, 1'b0, 1, 32'h0);           // pass-through after

        // reset during the 2nd BUSY cycle
        ctrl_wb_in = 2'b01; rd_in = 5'd3; alu_result_in = 32'h400; wdata_in = 32'h0;
        mem_read_in = 1'b1; mem_write_in = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("mr_issue_stall", 32'(stall), 32'd1);
        step();
        step();
        chk("mr_req_busy", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req", 32'(dmem_req), 32'd0);
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_outs", {25'd0, ctrl_wb_out, rd_out}, 32'd0);
        chk("mr_mdata", mem_data_out, 32'd0);
        chk("mr_alu", alu_result_out, 32'd0);
        chk("mr_addr", dmem_addr, 32'd0);
        m_mem = 32'h0;
        step();
        ctrl_wb_in = 2'b00; rd_in = 5'd0; alu_result_in = 32'h0;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;   // late ack from the abandoned access
        step();
        dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("late_req", 32'(dmem_req), 32'd0);
            chk("late_mdata", mem_data_out, 32'd0);
            chk("late_ctrl", 32'(ctrl_wb_out), 32'd0);
            chk("late_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
            chk("late_stall", 32'(stall), 32'd0);
            step();
        end

        // randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            if (kind < 8) a = a & ~32'h3;
            if (kind < 2) begin
                r = 1'b0; w = 1'b0;
            end else begin
                r = 1'($urandom_range(0, 1));
                w = r ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            run_instr(2'($urandom), 5'($urandom), a, $urandom, r, w,
                      int'($urandom_range(1, TO + 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
